// File: rtl/led_pattern_ctrl_if.sv
// Control/status bundle for led_pattern_ctrl.
//   master : the sequencer side; drives power_now, step, pause and mode, and
//            observes led, wrap and dir_up.
//   slave  : the LED controller side.
// WIDTH must match the WIDTH of the led_pattern_ctrl instance it is bound to.
interface led_pattern_ctrl_if #(
  parameter int unsigned WIDTH = 8
);
  logic             power_now;  // block enable
  logic             step;       // single-cycle advance tick
  logic             pause;      // hold pattern, ignore step
  logic [1:0]       mode;       // 0 rot right, 1 rot left, 2 bounce, 3 fill
  logic [WIDTH-1:0] led;        // LED drive, active-high
  logic             wrap;       // one-cycle pulse at the end of each pattern period
  logic             dir_up;     // bounce direction, 1 = toward MSB

  modport master (
    output power_now, step, pause, mode,
    input  led, wrap, dir_up
  );

  modport slave (
    input  power_now, step, pause, mode,
    output led, wrap, dir_up
  );
endinterface

// File: rtl/led_pattern_ctrl.sv
// Running-light controller for a WIDTH-bit LED bank.
// Patterns: rotate right, rotate left, bounce (ping-pong), bar fill from the MSB.
// One position per qualified step; all outputs registered (1-cycle latency).
// Power-off or a mode change reloads the start pattern of the selected mode.
//
// Ports:
//   clk    : system clock
//   rst_n  : asynchronous active-low reset
//   bus    : led_pattern_ctrl_if.slave (power_now, step, pause, mode -> led, wrap, dir_up)
//
// Parameters:
//   WIDTH  : number of LEDs, 2..32
//   DIV    : step prescale ratio, 1..255, only used with STEP_DIV_EN
//
// Build option: define STEP_DIV_EN to insert an 8-bit step prescaler so that
// only every DIV-th step pulse advances the pattern.
module led_pattern_ctrl #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIV   = 4
) (
  input logic              clk,
  input logic              rst_n,
  led_pattern_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ModeRotR   = 2'd0,
    ModeRotL   = 2'd1,
    ModeBounce = 2'd2,
    ModeFill   = 2'd3
  } mode_e;

  localparam logic [WIDTH-1:0] Msb1    = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] Lsb1    = WIDTH'(1);
  localparam logic [WIDTH-1:0] AllOnes = '1;

  mode_e            mode_in;
  mode_e            mode_q, mode_d;
  logic [WIDTH-1:0] led_q, led_d;
  logic             wrap_q, wrap_d;
  logic             dir_up_q, dir_up_d;
  logic             reload;
  logic             qual_step;
  logic             led_onehot;

  assign mode_in    = mode_e'(bus.mode);
  // Power-off and mode change share the same reload behaviour; any step is dropped.
  assign reload     = !bus.power_now || (mode_in != mode_q);
  assign led_onehot = (led_q != '0) && ((led_q & (led_q - Lsb1)) == '0);

  function automatic logic [WIDTH-1:0] start_pattern(input mode_e m);
    logic [WIDTH-1:0] p;
    unique case (m)
      ModeRotR:   p = Msb1;
      ModeRotL:   p = Lsb1;
      ModeBounce: p = Msb1;
      ModeFill:   p = '0;
      default:    p = Msb1;
    endcase
    return p;
  endfunction

`ifdef STEP_DIV_EN
  localparam logic [7:0] DivLast = 8'(DIV - 1);

  logic [7:0] cnt_q, cnt_d;

  // Pause holds the count; reload (power-off or mode change) clears it.
  always_comb begin
    cnt_d     = cnt_q;
    qual_step = 1'b0;
    if (reload) begin
      cnt_d = '0;
    end else if (!bus.pause && bus.step) begin
      if (cnt_q == DivLast) begin
        cnt_d     = '0;
        qual_step = 1'b1;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  logic [7:0] unused_div;
  assign unused_div = 8'(DIV);
  assign qual_step  = bus.step;
`endif

  always_comb begin
    mode_d   = mode_q;
    led_d    = led_q;
    wrap_d   = 1'b0;
    dir_up_d = dir_up_q;
    if (reload) begin
      mode_d   = mode_in;
      led_d    = start_pattern(mode_in);
      dir_up_d = 1'b0;
    end else if (!bus.pause && qual_step) begin
      unique case (mode_q)
        ModeRotR: begin
          if (led_q == Lsb1) begin
            led_d  = Msb1;
            wrap_d = 1'b1;
          end else if (led_onehot) begin
            led_d = led_q >> 1;
          end else begin
            led_d = Msb1;
          end
        end
        ModeRotL: begin
          if (led_q == Msb1) begin
            led_d  = Lsb1;
            wrap_d = 1'b1;
          end else if (led_onehot) begin
            led_d = led_q << 1;
          end else begin
            led_d = Lsb1;
          end
        end
        ModeBounce: begin
          if (!led_onehot) begin
            led_d    = Msb1;
            dir_up_d = 1'b0;
          end else if (!dir_up_q) begin
            if (led_q == Lsb1) begin
              // Defensive: already at the bottom while moving down, turn around.
              led_d    = led_q << 1;
              dir_up_d = 1'b1;
            end else begin
              led_d    = led_q >> 1;
              // Turn in the same update that lands on LSB1.
              dir_up_d = (led_q == (Lsb1 << 1));
            end
          end else begin
            if (led_q == Msb1) begin
              led_d    = led_q >> 1;
              dir_up_d = 1'b0;
            end else begin
              led_d = led_q << 1;
              if (led_q == (Msb1 >> 1)) begin
                dir_up_d = 1'b0;
                wrap_d   = 1'b1;
              end
            end
          end
        end
        ModeFill: begin
          if (led_q == AllOnes) begin
            led_d  = '0;
            wrap_d = 1'b1;
          end else begin
            led_d = {1'b1, led_q[WIDTH-1:1]};
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q   <= ModeRotR;
      led_q    <= Msb1;
      wrap_q   <= 1'b0;
      dir_up_q <= 1'b0;
    end else begin
      mode_q   <= mode_d;
      led_q    <= led_d;
      wrap_q   <= wrap_d;
      dir_up_q <= dir_up_d;
    end
  end

  assign bus.led    = led_q;
  assign bus.wrap   = wrap_q;
  assign bus.dir_up = dir_up_q;

endmodule
